// File: rtl/npu_pkg.sv
// Shared constants for the NPU activation sequencer: NPU register map and FSM states.
package npu_pkg;

  localparam logic [31:0] TypeAddr   = 32'h0;
  localparam logic [31:0] InputAddr  = 32'h4;
  localparam logic [31:0] OutputAddr = 32'h8;

  typedef enum logic [2:0] {
    IDLE,
    SET_TYPE,
    WR_IN,
    RD_OUT,
    CAPTURE
  } state_e;

endpackage

// File: rtl/npu_seq_fifo.sv
// Result FIFO for the NPU sequencer; head entry is always visible on pop_data_o.
module npu_seq_fifo #(
  parameter int DWidth = 32,
  parameter int Depth  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [DWidth-1:0]        push_data_i,
  input  logic                     pop_i,
  output logic [DWidth-1:0]        pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int PtrW = $clog2(Depth);

  logic [DWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full_o  = (cnt_q == (PtrW+1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  // Pops on empty are dropped; a push into a full FIFO only lands alongside a pop.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/npu_seq.sv
// Feeds samples through the NPU (type write, input write, output read) and queues results.
module npu_seq
  import npu_pkg::*;
#(
  parameter int DWidth = 32,
  parameter int Depth  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DWidth-1:0] cfg_type_i,
  input  logic              in_valid_i,
  input  logic [DWidth-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DWidth-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              cen_o,
  output logic              wen_o,
  output logic [DWidth-1:0] addr_o,
  output logic [DWidth-1:0] wdata_o,
  input  logic [DWidth-1:0] rdata_i
);

  localparam int CntW = $clog2(Depth) + 1;

  state_e            state_q, state_d;
  logic [DWidth-1:0] sample_q, sample_d;
  logic [DWidth-1:0] shadow_q, shadow_d;
  logic              dirty_q, dirty_d;
  logic              type_dirty, accept, push, full, empty;
  logic [CntW-1:0]   count;

  // A type change in the acceptance cycle itself must still trigger a rewrite.
  assign type_dirty  = dirty_q | (cfg_type_i != shadow_q);
  assign in_ready_o  = ~rst_i & (state_q == IDLE) & (count < CntW'(Depth));
  assign accept      = in_valid_i & in_ready_o;
  assign push        = (state_q == CAPTURE) & ~full;
  assign busy_o      = (state_q != IDLE);
  assign out_valid_o = ~empty;

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    shadow_d = shadow_q;
    dirty_d  = dirty_q | (cfg_type_i != shadow_q);
    cen_o    = 1'b0;
    wen_o    = 1'b0;
    addr_o   = '0;
    wdata_o  = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sample_d = in_data_i;
          state_d  = type_dirty ? SET_TYPE : WR_IN;
        end
      end
      SET_TYPE: begin
        cen_o    = 1'b1;
        wen_o    = 1'b1;
        addr_o   = DWidth'(TypeAddr);
        wdata_o  = cfg_type_i;
        shadow_d = cfg_type_i;
        dirty_d  = 1'b0;
        state_d  = WR_IN;
      end
      WR_IN: begin
        cen_o   = 1'b1;
        wen_o   = 1'b1;
        addr_o  = DWidth'(InputAddr);
        wdata_o = sample_q;
        state_d = RD_OUT;
      end
      RD_OUT: begin
        cen_o   = 1'b1;
        addr_o  = DWidth'(OutputAddr);
        state_d = CAPTURE;
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      sample_q <= '0;
      shadow_q <= '0;
      dirty_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      shadow_q <= shadow_d;
      dirty_q  <= dirty_d;
    end
  end

  npu_seq_fifo #(
    .DWidth(DWidth),
    .Depth (Depth)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .push_data_i(rdata_i),
    .pop_i      (out_ready_i),
    .pop_data_o (out_data_o),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count)
  );

endmodule

// File: tb/tb_npu_seq.sv
// Directed bench for npu_seq with a tiny NPU model: result = (type << 8) + input.
module tb_npu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_type, in_data, out_data, addr, wdata, rdata;
  logic        in_valid, in_ready, out_valid, out_ready, busy, cen, wen;

  logic [31:0] npu_type, npu_in;
  int checks = 0;
  int errors = 0;

  npu_seq #(.DWidth(32), .Depth(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cfg_type_i (cfg_type),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_ready_i(out_ready),
    .busy_o     (busy),
    .cen_o      (cen),
    .wen_o      (wen),
    .addr_o     (addr),
    .wdata_o    (wdata),
    .rdata_i    (rdata)
  );

  always #5 clk = ~clk;

  initial begin
    npu_type = 32'h0;
    npu_in   = 32'h0;
    rdata    = 32'h0;
  end

  always @(posedge clk) begin
    if (cen && wen && addr == 32'h0) npu_type <= wdata;
    if (cen && wen && addr == 32'h4) npu_in   <= wdata;
    if (cen && !wen && addr == 32'h8) rdata   <= (npu_type << 8) + npu_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input string tag, input logic c, input logic w,
                     input logic [31:0] a, input logic [31:0] d);
    chk({tag, " cen"}, 32'(cen), 32'(c));
    chk({tag, " wen"}, 32'(wen), 32'(w));
    chk({tag, " addr"}, addr, a);
    chk({tag, " wdata"}, wdata, d);
  endtask

  // Sample with unchanged type: accept edge + WR_IN, RD_OUT, CAPTURE -> back in IDLE.
  task automatic send_fast(input logic [31:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; cfg_type = 32'h0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    #1;
    chk("rst in_ready", 32'(in_ready), 32'h0);
    chk("rst out_valid", 32'(out_valid), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst out_data", out_data, 32'h0);
    bus("rst", 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("post-rst in_ready", 32'(in_ready), 32'h1);

    // First sample: type write, input write, output read on consecutive cycles
    cfg_type = 32'h2; in_data = 32'h10; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    bus("s1 SET_TYPE", 1'b1, 1'b1, 32'h0, 32'h2);
    chk("s1 busy", 32'(busy), 32'h1);
    chk("s1 in_ready", 32'(in_ready), 32'h0);
    tick();
    bus("s1 WR_IN", 1'b1, 1'b1, 32'h4, 32'h10);
    tick();
    bus("s1 RD_OUT", 1'b1, 1'b0, 32'h8, 32'h0);
    tick();
    bus("s1 CAPTURE", 1'b0, 1'b0, 32'h0, 32'h0);
    chk("s1 valid early", 32'(out_valid), 32'h0);
    tick();
    chk("s1 valid at 5", 32'(out_valid), 32'h1);
    chk("s1 data", out_data, 32'h210);
    chk("s1 idle", 32'(busy), 32'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("s1 popped", 32'(out_valid), 32'h0);

    // Same type: no type write, 4-cycle latency
    in_data = 32'h20; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    bus("s2 WR_IN", 1'b1, 1'b1, 32'h4, 32'h20);
    tick();
    bus("s2 RD_OUT", 1'b1, 1'b0, 32'h8, 32'h0);
    tick();
    chk("s2 valid early", 32'(out_valid), 32'h0);
    tick();
    chk("s2 valid at 4", 32'(out_valid), 32'h1);
    chk("s2 data", out_data, 32'h220);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Fill the FIFO with the consumer stalled; the fifth sample must wait
    for (int i = 0; i < 4; i++) send_fast(32'h31 + 32'(i));
    chk("full in_ready", 32'(in_ready), 32'h0);
    chk("full head", out_data, 32'h231);
    in_data = 32'h35; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full stall ready", 32'(in_ready), 32'h0);
      chk("full stall busy", 32'(busy), 32'h0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("after pop in_ready", 32'(in_ready), 32'h1);
    chk("after pop head", out_data, 32'h232);
    tick();
    in_valid = 1'b0;
    chk("fifth accepted", 32'(busy), 32'h1);
    tick();
    tick();
    tick();
    chk("refull in_ready", 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain order", out_data, 32'h232 + 32'(i));
      tick();
    end
    out_ready = 1'b0;
    chk("drained", 32'(out_valid), 32'h0);

    // Push and pop together in CAPTURE with one entry held
    send_fast(32'h40);
    chk("one entry head", out_data, 32'h240);
    in_data = 32'h41; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("in CAPTURE", 32'(busy), 32'h1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("simul valid", 32'(out_valid), 32'h1);
    chk("simul head", out_data, 32'h241);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("simul count 1", 32'(out_valid), 32'h0);

    // Type change during WR_IN applies only to the next sample
    in_data = 32'h50; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cfg_type = 32'h3;
    bus("s5 WR_IN", 1'b1, 1'b1, 32'h4, 32'h50);
    tick();
    bus("s5 RD_OUT", 1'b1, 1'b0, 32'h8, 32'h0);
    tick();
    tick();
    chk("s5 data", out_data, 32'h250);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_data = 32'h51; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    bus("s6 SET_TYPE", 1'b1, 1'b1, 32'h0, 32'h3);
    tick();
    tick();
    tick();
    tick();
    chk("s6 data", out_data, 32'h351);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset during RD_OUT aborts at once; next sample rewrites the type
    in_data = 32'h60; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    bus("s7 RD_OUT", 1'b1, 1'b0, 32'h8, 32'h0);
    #1 rst = 1'b1;
    #1;
    chk("abort cen", 32'(cen), 32'h0);
    chk("abort busy", 32'(busy), 32'h0);
    chk("abort in_ready", 32'(in_ready), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("abort fifo empty", 32'(out_valid), 32'h0);
    chk("abort in_ready after", 32'(in_ready), 32'h1);
    in_data = 32'h61; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    bus("s8 SET_TYPE", 1'b1, 1'b1, 32'h0, 32'h3);
    tick();
    bus("s8 WR_IN", 1'b1, 1'b1, 32'h4, 32'h61);
    tick();
    tick();
    tick();
    chk("s8 valid", 32'(out_valid), 32'h1);
    chk("s8 data", out_data, 32'h361);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/npu_seq.md
NPU_SEQ -- requirements
Module: npu_seq

Interface
REQ-001 The block SHALL have these parameters: DWidth, default 32, data/address width; Depth, default 4, output FIFO entries (power of 2, at least 2).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 The ports SHALL be:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- cfg_type_i  in  DWidth  activation type to apply to every sample
- in_valid_i  in  1  input sample valid
- in_data_i  in  DWidth  input sample
- in_ready_o  out  1  sample accepted when in_valid_i and in_ready_o are both high
- out_valid_o  out  1  result available
- out_data_o  out  DWidth  result (head of the FIFO)
- out_ready_i  in  1  result consumed when out_valid_o and out_ready_i are both high
- busy_o  out  1  state is not IDLE
- cen_o  out  1  NPU access enable, active-high
- wen_o  out  1  NPU access type, 1 = write, 0 = read
- addr_o  out  DWidth  NPU register address
- wdata_o  out  DWidth  NPU write data
- rdata_i  in  DWidth  NPU read data, valid one cycle after the read access

Function
REQ-004 The FSM SHALL have the states IDLE, SET_TYPE, WR_IN, RD_OUT and CAPTURE, and each state SHALL last exactly one cycle except IDLE.
REQ-005 in_ready_o SHALL be high only in IDLE when the FIFO count is less than Depth.
REQ-006 On acceptance, in_data_i SHALL be latched and the FSM SHALL go to SET_TYPE if type_dirty is set, otherwise to WR_IN.
REQ-007 type_dirty SHALL be set out of reset, and SHALL be set whenever cfg_type_i differs from the shadow register of the last written type.
REQ-008 SET_TYPE SHALL drive cen_o=1, wen_o=1, addr_o=0x0 and wdata_o=cfg_type_i; it SHALL update the shadow register, clear type_dirty and go to WR_IN.
REQ-009 WR_IN SHALL drive cen_o=1, wen_o=1, addr_o=0x4 and wdata_o equal to the latched sample, then go to RD_OUT.
REQ-010 RD_OUT SHALL drive cen_o=1, wen_o=0 and addr_o=0x8, then go to CAPTURE.
REQ-011 CAPTURE SHALL push rdata_i into the FIFO and return to IDLE.
REQ-012 In IDLE and CAPTURE the block SHALL drive cen_o=0 and wen_o=0, and SHALL hold addr_o and wdata_o at 0.
REQ-013 out_valid_o SHALL rise in the cycle after the CAPTURE cycle.
REQ-014 Latency from acceptance to out_valid_o SHALL be 4 cycles when the type is unchanged and 5 cycles when the type is rewritten.
REQ-015 Throughput SHALL be one sample per 4 cycles, because IDLE lasts at least one cycle per sample.
REQ-016 The FIFO SHALL allow a push and a pop in the same cycle; in that case the count is unchanged and the data order is preserved.
REQ-017 out_data_o SHALL always show the head entry.
REQ-018 The FIFO pointers SHALL wrap modulo Depth.
REQ-019 A pop SHALL be ignored when the FIFO is empty.
REQ-020 A push into a full FIFO SHALL be impossible, because acceptance requires count < Depth and pops only lower the count.
REQ-021 A change of cfg_type_i while busy SHALL NOT affect the sample in flight past SET_TYPE; it SHALL apply to the next sample.

Reset
REQ-022 Reset SHALL set the FSM to IDLE, empty the FIFO, clear the shadow register and set type_dirty.
REQ-023 Reset SHALL drive every output to 0, except in_ready_o, which becomes 1 in the first cycle after reset deassertion.
REQ-024 Reset asserted mid-sequence SHALL abort the sequence immediately, with no further NPU access.

Structure
REQ-025 Package npu_pkg SHALL hold the register address constants TypeAddr=0x0, InputAddr=0x4 and OutputAddr=0x8, plus the FSM state enum.
REQ-026 The output FIFO SHALL be the sub-module npu_seq_fifo (parameters DWidth and Depth; push, pop, full, empty, count).
REQ-027 The FSM and the type shadow register SHALL be in npu_seq.

Verification
REQ-028 Reset, then cfg_type_i=2 and one sample 0x10 -> NPU accesses W 0x0=2, W 0x4=0x10, R 0x8 on consecutive cycles, then one FIFO result.
REQ-029 Second sample 0x20 with the type unchanged -> no write to 0x0; out_valid_o rises 4 cycles after acceptance.
REQ-030 out_ready_i=0 and 5 samples offered with Depth=4 -> 4 accepted, in_ready_o stays low, then one pop lets the fifth sample through.
REQ-031 FIFO holds 1 entry, pop in the same cycle as CAPTURE -> count stays 1 and the data order is preserved.
REQ-032 cfg_type_i changed from 2 to 3 during WR_IN -> the current sample completes without a type write, and the next sample begins with W 0x0=3.
REQ-033 rst_i asserted during RD_OUT -> cen_o=0 in the same cycle, FIFO empty, and the next sample rewrites the type.
